// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: load-type codes, FSM states
// and requester indices.
package dmem_pkg;

  localparam logic [1:0] LT_WORD    = 2'b00;
  localparam logic [1:0] LT_HALF    = 2'b01;
  localparam logic [1:0] LT_BYTE    = 2'b10;
  localparam logic [1:0] LT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  localparam logic CPU = 1'b0;
  localparam logic LDR = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request fields toward the
// arbiter, completion/status/read data back to the requester.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [1:0]        load_type;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  modport master (
    output req, we, load_type, addr, wdata,
    input  done, err, rdata
  );

  modport slave (
    input  req, we, load_type, addr, wdata,
    output done, err, rdata
  );

endinterface

// File: rtl/dmem_align_check.sv
// Combinational legality check for a data-memory access; also used by the
// CPU exception logic.
module dmem_align_check
  import dmem_pkg::*;
(
  input  logic [1:0] load_type,
  input  logic [1:0] addr_lo,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b1;
    case (load_type)
      LT_WORD:    illegal = (addr_lo != 2'b00);
      LT_HALF:    illegal = addr_lo[0];
      LT_BYTE:    illegal = 1'b0;
      LT_ILLEGAL: illegal = 1'b1;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing DMem between the CPU load/store unit and the
// boot loader; sequences each access over the fixed memory read latency.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  dmem_arbiter_if.slave c,
  dmem_arbiter_if.slave l,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_load_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              grant_q, prefer_q;
  logic              err_q;
  logic              we_q;
  logic [1:0]        lt_q;
  logic [31:0]       addr_q, wdata_q;
  logic [31:0]       c_rdata_q, l_rdata_q;

  logic              any_req, grant_sel, illegal, last_beat;
  logic              sel_we;
  logic [1:0]        sel_lt;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;

  // Both requesting: take the one not served last; otherwise the only one.
  always_comb begin
    any_req = c.req | l.req;
    if (c.req && l.req) grant_sel = prefer_q;
    else                grant_sel = l.req ? LDR : CPU;
    sel_we    = (grant_sel == LDR) ? l.we        : c.we;
    sel_lt    = (grant_sel == LDR) ? l.load_type : c.load_type;
    sel_addr  = (grant_sel == LDR) ? l.addr      : c.addr;
    sel_wdata = (grant_sel == LDR) ? l.wdata     : c.wdata;
  end

  dmem_align_check u_align (
    .load_type (sel_lt),
    .addr_lo   (sel_addr[1:0]),
    .illegal   (illegal)
  );

  assign last_beat = (cnt_q == CNT_W'(MEM_LAT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    c.done    = 1'b0;
    l.done    = 1'b0;
    case (state_q)
      IDLE: if (any_req) state_d = illegal ? DONE : BUSY;
      BUSY: begin
        mem_read  = ~we_q;
        mem_write = we_q;
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        c.done  = (grant_q == CPU);
        l.done  = (grant_q == LDR);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    c.err = c.done & err_q;
    l.err = l.done & err_q;
  end

  // The mem_* copies are only reloaded by legal grants so DMem never sees a
  // rejected address on its inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      grant_q   <= CPU;
      prefer_q  <= CPU;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      lt_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          grant_q  <= grant_sel;
          prefer_q <= ~grant_sel;
          err_q    <= illegal;
          cnt_q    <= '0;
          if (!illegal) begin
            we_q    <= sel_we;
            lt_q    <= sel_lt;
            addr_q  <= 32'(sel_addr);
            wdata_q <= sel_wdata;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_beat && !we_q) begin
            if (grant_q == CPU) c_rdata_q <= mem_dout;
            else                l_rdata_q <= mem_dout;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_load_type = lt_q;
  assign mem_addr      = addr_q;
  assign mem_din       = wdata_q;
  assign c.rdata       = c_rdata_q;
  assign l.rdata       = l_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a table of single accesses plus hand-written
// sequences for round-robin, reset mid-access and field changes while busy.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  typedef struct {
    bit          ldr;
    logic        we;
    logic [1:0]  lt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dout;
    int          exp_lat;
    logic        exp_err;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  mem_load_type;
  logic [31:0] mem_addr, mem_din, mem_dout;

  dmem_arbiter_if #(.ADDR_W(32)) c_if ();
  dmem_arbiter_if #(.ADDR_W(32)) l_if ();

  dmem_arbiter #(.MEM_LAT(2), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .c             (c_if),
    .l             (l_if),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_load_type (mem_load_type),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_dout      (mem_dout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          obs_lat, obs_done_cnt, obs_other_done, obs_rd, obs_wr;
  int          obs_addr_bad, obs_din_bad, obs_lt_bad;
  logic        obs_err;
  logic [31:0] obs_rdata;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    c_if.req = 0; c_if.we = 0; c_if.load_type = 0; c_if.addr = 0; c_if.wdata = 0;
    l_if.req = 0; l_if.we = 0; l_if.load_type = 0; l_if.addr = 0; l_if.wdata = 0;
    mem_dout = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1;
    clearInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  // Runs one access in a fixed 6-cycle window and records what the DUT did.
  task automatic applyStimulus(input vec_t v);
    logic done_g, done_o, err_g;
    obs_lat = -1; obs_done_cnt = 0; obs_other_done = 0; obs_rd = 0; obs_wr = 0;
    obs_addr_bad = 0; obs_din_bad = 0; obs_lt_bad = 0; obs_err = 0;
    @(negedge clk);
    mem_dout = v.dout;
    if (v.ldr) begin
      l_if.req = 1; l_if.we = v.we; l_if.load_type = v.lt; l_if.addr = v.addr; l_if.wdata = v.wdata;
    end else begin
      c_if.req = 1; c_if.we = v.we; c_if.load_type = v.lt; c_if.addr = v.addr; c_if.wdata = v.wdata;
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      done_g = v.ldr ? l_if.done : c_if.done;
      done_o = v.ldr ? c_if.done : l_if.done;
      err_g  = v.ldr ? l_if.err  : c_if.err;
      if (mem_read)  obs_rd++;
      if (mem_write) obs_wr++;
      if ((mem_read || mem_write) && mem_addr !== v.addr)    obs_addr_bad++;
      if ((mem_read || mem_write) && mem_load_type !== v.lt) obs_lt_bad++;
      if (mem_write && mem_din !== v.wdata)                  obs_din_bad++;
      if (done_o) obs_other_done++;
      if (done_g) begin
        obs_done_cnt++;
        if (obs_lat < 0) begin
          obs_lat = k;
          obs_err = err_g;
        end
        @(negedge clk);
        c_if.req = 0;
        l_if.req = 0;
      end
    end
    obs_rdata = v.ldr ? l_if.rdata : c_if.rdata;
  endtask

  task automatic checkVector(input vec_t v, input string tag);
    checkOutput({tag, "_latency"},    obs_lat,        v.exp_lat);
    checkOutput({tag, "_err"},        32'(obs_err),   32'(v.exp_err));
    checkOutput({tag, "_done_count"}, obs_done_cnt,   1);
    checkOutput({tag, "_other_done"}, obs_other_done, 0);
    checkOutput({tag, "_read_cyc"},   obs_rd,         v.exp_rd);
    checkOutput({tag, "_write_cyc"},  obs_wr,         v.exp_wr);
    checkOutput({tag, "_mem_addr"},   obs_addr_bad,   0);
    checkOutput({tag, "_mem_lt"},     obs_lt_bad,     0);
    checkOutput({tag, "_mem_din"},    obs_din_bad,    0);
    checkOutput({tag, "_rdata"},      obs_rdata,      v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          ev_cnt;
    int          ev_cyc[4];
    logic        ev_who[4];
    logic        exp_who;
    int          dn;

    //          ldr we  lt          addr      wdata          dout           lat err rd wr rdata
    vecs[0] = '{0, 0, LT_WORD,    32'h10,  32'h0,        32'hDEADBEEF, 3, 0, 2, 0, 32'hDEADBEEF};
    vecs[1] = '{1, 1, LT_BYTE,    32'h23,  32'h5A,       32'h11111111, 3, 0, 0, 2, 32'h0};
    vecs[2] = '{0, 0, LT_HALF,    32'h101, 32'h0,        32'h22222222, 1, 1, 0, 0, 32'hDEADBEEF};
    vecs[3] = '{1, 0, LT_HALF,    32'h22,  32'h0,        32'hFFFF8001, 3, 0, 2, 0, 32'hFFFF8001};
    vecs[4] = '{0, 0, LT_BYTE,    32'h7,   32'h0,        32'h00000042, 3, 0, 2, 0, 32'h00000042};
    vecs[5] = '{0, 1, LT_WORD,    32'h44,  32'h12345678, 32'h33333333, 3, 0, 0, 2, 32'h00000042};
    vecs[6] = '{1, 0, LT_ILLEGAL, 32'h0,   32'h0,        32'h44444444, 1, 1, 0, 0, 32'hFFFF8001};
    vecs[7] = '{0, 1, LT_WORD,    32'h46,  32'h9,        32'h55555555, 1, 1, 0, 0, 32'h00000042};
    vecs[8] = '{1, 0, LT_WORD,    32'h100, 32'h0,        32'hCAFEF00D, 3, 0, 2, 0, 32'hCAFEF00D};

    rst = 1;
    clearInputs();
    doReset();

    @(posedge clk);
    #1;
    checkOutput("rst_c_done",   32'(c_if.done), 0);
    checkOutput("rst_c_err",    32'(c_if.err),  0);
    checkOutput("rst_c_rdata",  c_if.rdata,     0);
    checkOutput("rst_l_done",   32'(l_if.done), 0);
    checkOutput("rst_l_rdata",  l_if.rdata,     0);
    checkOutput("rst_mem_rw",   {30'd0, mem_read, mem_write}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_din",  mem_din,  0);

    // Round-robin: both hold req continuously from reset.
    @(negedge clk);
    mem_dout = 32'hA5A5A5A5;
    c_if.req = 1; c_if.we = 0; c_if.load_type = LT_WORD; c_if.addr = 32'h200;
    l_if.req = 1; l_if.we = 0; l_if.load_type = LT_WORD; l_if.addr = 32'h300;
    ev_cnt  = 0;
    exp_who = CPU;
    for (int k = 1; k <= 30 && ev_cnt < 4; k++) begin
      @(posedge clk);
      #1;
      if (mem_read) checkOutput("rr_mem_addr", mem_addr, (exp_who == LDR) ? 32'h300 : 32'h200);
      if (c_if.done && l_if.done) checkOutput("rr_double_done", 1, 0);
      if (c_if.done || l_if.done) begin
        ev_cyc[ev_cnt] = k;
        ev_who[ev_cnt] = l_if.done;
        ev_cnt++;
        exp_who = ~exp_who;
      end
    end
    checkOutput("rr_event_count", ev_cnt, 4);
    for (int i = 0; i < ev_cnt; i++) begin
      checkOutput($sformatf("rr_who%0d", i), 32'(ev_who[i]), (i % 2 == 1) ? 1 : 0);
      checkOutput($sformatf("rr_cycle%0d", i), ev_cyc[i], 3 + 4 * i);
    end
    @(negedge clk);
    clearInputs();

    doReset();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i], $sformatf("v%0d", i));
    end

    // Reset during the first BUSY cycle of a store.
    @(negedge clk);
    c_if.req = 1; c_if.we = 1; c_if.load_type = LT_WORD; c_if.addr = 32'h80; c_if.wdata = 32'h77;
    @(posedge clk);
    #1;
    checkOutput("rstbusy_write_on", 32'(mem_write), 1);
    @(negedge clk);
    rst = 1;
    c_if.req = 0;
    @(posedge clk);
    #1;
    checkOutput("rstbusy_write_off", {30'd0, mem_read, mem_write}, 0);
    @(negedge clk);
    rst = 0;
    dn = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (c_if.done || l_if.done) dn++;
    end
    checkOutput("rstbusy_no_done", dn, 0);
    begin
      vec_t fresh;
      fresh = '{0, 0, LT_WORD, 32'h84, 32'h0, 32'h13572468, 3, 0, 2, 0, 32'h13572468};
      applyStimulus(fresh);
      checkVector(fresh, "rstbusy_fresh");
    end

    // Address changes while BUSY must not reach DMem.
    @(negedge clk);
    mem_dout = 32'h0BADF00D;
    c_if.req = 1; c_if.we = 0; c_if.load_type = LT_WORD; c_if.addr = 32'h10;
    @(posedge clk);
    #1;
    checkOutput("hold_addr_b1", mem_addr, 32'h10);
    @(negedge clk);
    c_if.addr = 32'h40;
    @(posedge clk);
    #1;
    checkOutput("hold_addr_b2", mem_addr, 32'h10);
    checkOutput("hold_read_b2", 32'(mem_read), 1);
    @(posedge clk);
    #1;
    checkOutput("hold_done",  32'(c_if.done), 1);
    checkOutput("hold_rdata", c_if.rdata, 32'h0BADF00D);
    @(negedge clk);
    c_if.req = 0;
    @(posedge clk);
    #1;
    checkOutput("hold_done_pulse", 32'(c_if.done), 0);
    checkOutput("hold_addr_idle",  mem_addr, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
